beat_sequencer: RTL and testbench
=================================

Name: beat_sequencer

Overview:
- Game-timing stage directly upstream of the per-bar key-press checker.
- Generates the beat position `beat_cnt` (0..BAR_LEN) and the freeze flag `stop_or_end` that the checker consumes.
- Samples the checker's `wrong` flag once per bar and keeps the lives count.
- Runs the IDLE/PLAY/PAUSE/END game flow that ends the song as cleared or game over.

Parameters:
- CLK_DIV, 1_000_000: clk cycles per beat tick; must be >= 2.
- BAR_LEN, 96: final beat value of a bar; the checker clears on this value. Must fit in 7 bits.
- NUM_BARS, 16: bars per song.
- LIVES, 3: starting lives, 1..3.

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- restart  in  1  synchronous, level; returns to IDLE with everything cleared
- start  in  1  one-cycle pulse; begins play from IDLE
- pause  in  1  one-cycle pulse; toggles PLAY/PAUSE
- wrong  in  1  mismatch flag from the key-press checker
- beat_cnt  out  7  beat position within the bar, 0..BAR_LEN
- bar_idx  out  $clog2(NUM_BARS)  current bar, 0..NUM_BARS-1
- stop_or_end  out  1  high in IDLE, PAUSE and END
- bar_end  out  1  one-cycle pulse on the first cycle beat_cnt==BAR_LEN
- lives  out  2  remaining lives
- cleared  out  1  song finished with lives > 0; sticky until restart or reset
- game_over  out  1  lives reached 0; sticky until restart or reset

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE.
  - div_cnt=0, beat_cnt=0, bar_idx=0, lives=LIVES.
  - bar_end=0, cleared=0, game_over=0, stop_or_end=1.
- All outputs are registered except stop_or_end, which is decoded from the state register.
- Priority at each edge: rst_n > restart > bar-end evaluation > pause > start.
- restart: next state IDLE; every register returns to its reset value.
- IDLE:
  - start=1 -> PLAY; div_cnt, beat_cnt and bar_idx are already 0.
  - pause is ignored.
- PLAY:
  - div_cnt counts 0..CLK_DIV-1; tick is the cycle in which div_cnt==CLK_DIV-1.
  - On tick: if beat_cnt<BAR_LEN, beat_cnt+1; if beat_cnt==BAR_LEN, beat_cnt->0 and bar_idx+1.
  - beat_cnt therefore holds BAR_LEN for one full tick period; the checker's count stays cleared during that period.
- bar_end:
  - Asserted for exactly one cycle: the first cycle in which beat_cnt==BAR_LEN.
  - In that cycle the checker still holds the completed bar's count, so wrong is sampled in that cycle only.
- Life update at bar_end:
  - wrong=1 and lives>1: lives-1.
  - wrong=1 and lives==1: lives->0, game_over->1, next state END.
  - game_over takes precedence over cleared in the same cycle.
  - Otherwise, if bar_idx==NUM_BARS-1: cleared->1, next state END.
- pause pulse:
  - In PLAY -> PAUSE; in PAUSE -> PLAY.
  - In PAUSE, div_cnt, beat_cnt and bar_idx are frozen.
  - A pause in the same cycle as a bar_end that ends the game is ignored (END wins).
- END: all counters frozen; beat_cnt stays at BAR_LEN. start and pause are ignored; only restart or rst_n leave END.
- start in PLAY, PAUSE or END: ignored.
- Widths and ranges:
  - beat_cnt never exceeds BAR_LEN.
  - bar_idx never wraps; END is entered at the last bar.
  - lives never underflows.

Decomposition:
- Shared package beat_pkg:
  - State encoding: ST_IDLE=2'd0, ST_PLAY=2'd1, ST_PAUSE=2'd2, ST_END=2'd3.
  - Default constants: BAR_LEN_DEF=7'd96, CLK_DIV_DEF.
- One natural sub-module, beat_prescaler: div_cnt plus tick generation, with enable and clear inputs.
- The FSM, beat/bar counters and lives logic stay in beat_sequencer.

Test Plan:
(All scenarios use CLK_DIV=2, BAR_LEN=96, NUM_BARS=2, LIVES=2.)
1. Reset, then start pulse -> stop_or_end falls the next cycle. beat_cnt reaches 1 after 2 cycles and 96 after 192 cycles; bar_end pulses for 1 cycle; beat_cnt->0 and bar_idx->1 two cycles later.
2. Hold wrong=0 through both bars -> at the bar_end with bar_idx=1, cleared=1, state END, stop_or_end=1, beat_cnt stays 96 and lives=2.
3. wrong=1 at both bar_ends -> lives 2->1 after bar 0; at bar 1, lives=0 and game_over=1 with cleared=0, even though it is also the last bar.
4. pause at beat_cnt=40, hold 50 cycles, pause again -> beat_cnt stays 40 and stop_or_end=1 throughout; counting resumes with div_cnt at its frozen value.
5. restart during PLAY at beat_cnt=70 -> next edge: IDLE, beat_cnt=0, bar_idx=0, lives=2, flags 0. A start in the same cycle as restart is ignored.
6. rst_n pulsed low mid-bar, asynchronous to clk -> outputs reach reset values immediately, with no clock edge needed. wrong toggling outside bar_end cycles never changes lives.

Source files
------------

// File: rtl/beat_pkg.sv
// Shared definitions for the beat sequencer game-timing stage.
//   state_e       : game-flow state encoding (IDLE/PLAY/PAUSE/END)
//   *_DEF         : default parameter values
//   bar_w()       : width of a bar index for a given bar count (min 1)
package beat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_END   = 2'd3
  } state_e;

  localparam logic [6:0] BAR_LEN_DEF  = 7'd96;
  localparam int         CLK_DIV_DEF  = 1_000_000;
  localparam int         NUM_BARS_DEF = 16;
  localparam int         LIVES_DEF    = 3;

  function automatic int bar_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/beat_prescaler.sv
// Beat prescaler: counts clk cycles 0..CLK_DIV-1 while enabled and flags
// the last cycle of each period as a tick.
//   clk, rst_n : clock, async active-low reset
//   en         : count enable (counter frozen when low)
//   clr        : synchronous clear, wins over en
//   tick       : combinational, high in the cycle div_cnt==CLK_DIV-1 and en
module beat_prescaler
  import beat_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              DW      = $clog2(CLK_DIV);
  localparam logic [DW-1:0]   DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;

  assign tick = en && (div_cnt_q == DIV_MAX);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr)       div_cnt_d = '0;
    else if (tick) div_cnt_d = '0;
    else if (en)   div_cnt_d = div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt_q <= '0;
    else        div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/beat_sequencer.sv
// Beat sequencer: produces the beat position and freeze flag consumed by the
// per-bar key-press checker, samples the checker's wrong flag once per bar,
// keeps the lives count and runs the IDLE/PLAY/PAUSE/END game flow.
//   clk, rst_n  : clock, async active-low reset
//   restart     : sync level, back to IDLE with everything cleared
//   start/pause : one-cycle pulses (begin play / toggle PLAY-PAUSE)
//   wrong       : checker mismatch, only looked at during bar_end
//   beat_cnt    : 0..BAR_LEN within the bar
//   bar_idx     : current bar 0..NUM_BARS-1
//   stop_or_end : high whenever not in PLAY (decoded from state)
//   bar_end     : one-cycle pulse, first cycle of beat_cnt==BAR_LEN
//   lives, cleared, game_over : game result (flags sticky until restart)
module beat_sequencer
  import beat_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int BAR_LEN  = int'(BAR_LEN_DEF),
  parameter int NUM_BARS = NUM_BARS_DEF,
  parameter int LIVES    = LIVES_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        restart,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        wrong,
  output logic [6:0]                  beat_cnt,
  output logic [bar_w(NUM_BARS)-1:0]  bar_idx,
  output logic                        stop_or_end,
  output logic                        bar_end,
  output logic [1:0]                  lives,
  output logic                        cleared,
  output logic                        game_over
);

  localparam int           BW        = bar_w(NUM_BARS);
  localparam logic [6:0]   BEAT_LAST = 7'(BAR_LEN);
  localparam logic [6:0]   BEAT_PRE  = 7'(BAR_LEN - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(NUM_BARS - 1);
  localparam logic [1:0]   LIVES_INI = 2'(LIVES);

  state_e          state_q, state_d;
  logic [6:0]      beat_q, beat_d;
  logic [BW-1:0]   bar_q, bar_d;
  logic [1:0]      lives_q, lives_d;
  logic            bar_end_q, bar_end_d;
  logic            cleared_q, cleared_d;
  logic            game_over_q, game_over_d;
  logic            tick;
  logic            end_game;

  // Prescaler only runs in PLAY, so PAUSE/END freeze it mid-period and
  // play resumes exactly where it stopped.
  beat_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == ST_PLAY),
    .clr   (restart),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    bar_d       = bar_q;
    lives_d     = lives_q;
    bar_end_d   = 1'b0;
    cleared_d   = cleared_q;
    game_over_d = game_over_q;
    end_game    = 1'b0;

    if (restart) begin
      state_d     = ST_IDLE;
      beat_d      = '0;
      bar_d       = '0;
      lives_d     = LIVES_INI;
      cleared_d   = 1'b0;
      game_over_d = 1'b0;
    end else begin
      // Beat/bar advance. bar_end is registered alongside the step into
      // BAR_LEN so it lines up with the first cycle of that value.
      if (state_q == ST_PLAY && tick) begin
        if (beat_q == BEAT_LAST) begin
          beat_d = '0;
          bar_d  = bar_q + 1'b1;
        end else begin
          beat_d    = beat_q + 1'b1;
          bar_end_d = (beat_q == BEAT_PRE);
        end
      end

      // The checker still holds the finished bar's result only during the
      // bar_end cycle, so wrong is consumed here and nowhere else.
      if (bar_end_q) begin
        if (wrong) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
          end else begin
            lives_d     = 2'd0;
            game_over_d = 1'b1;
            end_game    = 1'b1;
          end
        end else if (bar_q == BAR_LAST) begin
          cleared_d = 1'b1;
          end_game  = 1'b1;
        end
      end

      if (end_game) begin
        state_d = ST_END;
      end else begin
        unique case (state_q)
          ST_IDLE:  if (start) state_d = ST_PLAY;
          ST_PLAY:  if (pause) state_d = ST_PAUSE;
          ST_PAUSE: if (pause) state_d = ST_PLAY;
          default:  state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      bar_q       <= '0;
      lives_q     <= LIVES_INI;
      bar_end_q   <= 1'b0;
      cleared_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      bar_q       <= bar_d;
      lives_q     <= lives_d;
      bar_end_q   <= bar_end_d;
      cleared_q   <= cleared_d;
      game_over_q <= game_over_d;
    end
  end

  assign beat_cnt    = beat_q;
  assign bar_idx     = bar_q;
  assign lives       = lives_q;
  assign bar_end     = bar_end_q;
  assign cleared     = cleared_q;
  assign game_over   = game_over_q;
  assign stop_or_end = (state_q != ST_PLAY);

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer. The model tracks total cycles spent playing and
// derives beat/bar from that with plain division; game flow is kept as a
// small integer state.
module tb_beat_sequencer;

  localparam int CD = 2;
  localparam int BL = 96;
  localparam int NB = 2;
  localparam int LV = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic restart = 1'b0, start = 1'b0, pause = 1'b0, wrong = 1'b0;
  logic [6:0]            beat_cnt;
  logic [$clog2(NB)-1:0] bar_idx;
  logic                  stop_or_end, bar_end, cleared, game_over;
  logic [1:0]            lives;

  int checks = 0;
  int errors = 0;

  beat_sequencer #(.CLK_DIV(CD), .BAR_LEN(BL), .NUM_BARS(NB), .LIVES(LV)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .start(start), .pause(pause),
    .wrong(wrong), .beat_cnt(beat_cnt), .bar_idx(bar_idx),
    .stop_or_end(stop_or_end), .bar_end(bar_end), .lives(lives),
    .cleared(cleared), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // m_st: 0 idle, 1 play, 2 pause, 3 end
  int m_play, m_lives, m_st;
  bit m_inc, m_clr, m_go;

  function automatic int m_beat();
    return (m_play / CD) % (BL + 1);
  endfunction
  function automatic int m_bar();
    return (m_play / CD) / (BL + 1);
  endfunction
  // first cycle at BAR_LEN: the last edge advanced play time onto a tick boundary
  function automatic bit m_bar_end();
    return m_inc && (m_play % CD == 0) && (m_beat() == BL);
  endfunction

  task automatic m_reset();
    m_play = 0; m_lives = LV; m_st = 0; m_inc = 0; m_clr = 0; m_go = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       m_reset();
    else if (restart) m_reset();
    else begin
      bit be, eg;
      int bar, ns;
      be = m_bar_end();
      bar = m_bar();
      ns = m_st;
      eg = 0;
      m_inc = (m_st == 1);
      if (m_inc) m_play++;
      if (be) begin
        if (wrong) begin
          if (m_lives > 1) m_lives--;
          else begin m_lives = 0; m_go = 1; eg = 1; end
        end else if (bar == NB - 1) begin
          m_clr = 1; eg = 1;
        end
      end
      if (eg)                      ns = 3;
      else if (pause && m_st == 1) ns = 2;
      else if (pause && m_st == 2) ns = 1;
      else if (start && m_st == 0) ns = 1;
      m_st = ns;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic cmp_model();
    checks++;
    if (beat_cnt !== 7'(m_beat()) || bar_idx !== ($clog2(NB))'(m_bar()) ||
        stop_or_end !== (m_st != 1) || bar_end !== m_bar_end() ||
        lives !== 2'(m_lives) || cleared !== m_clr || game_over !== m_go) begin
      errors++;
      $display("FAIL model t=%0t got beat=%0d bar=%0d soe=%0d be=%0d lives=%0d clr=%0d go=%0d want beat=%0d bar=%0d soe=%0d be=%0d lives=%0d clr=%0d go=%0d",
               $time, beat_cnt, bar_idx, stop_or_end, bar_end, lives, cleared, game_over,
               m_beat(), m_bar(), (m_st != 1), m_bar_end(), m_lives, m_clr, m_go);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // compare against the model at the falling edge, then advance to just
  // after the next rising edge where stimulus is changed
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmp_model();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    chk("rst_beat", beat_cnt, 0);
    chk("rst_bar", bar_idx, 0);
    chk("rst_lives", lives, 2);
    chk("rst_soe", stop_or_end, 1);
    chk("rst_flags", {bar_end, cleared, game_over}, 0);

    // 1: first bar timing
    start = 1'b1; step(1); start = 1'b0;
    chk("s1_soe_fall", stop_or_end, 0);
    step(2);   chk("s1_beat1", beat_cnt, 1);
    step(190); chk("s1_beat96", beat_cnt, 96);
    chk("s1_bar_end", bar_end, 1);
    step(1);   chk("s1_bar_end_low", bar_end, 0);
    chk("s1_beat_hold", beat_cnt, 96);
    step(1);   chk("s1_wrap_beat", beat_cnt, 0);
    chk("s1_wrap_bar", bar_idx, 1);

    // 2: clear the song
    wrong = 1'b0;
    step(192); chk("s2_last_bar_end", bar_end, 1);
    step(1);
    chk("s2_cleared", cleared, 1);
    chk("s2_soe", stop_or_end, 1);
    chk("s2_lives", lives, 2);
    step(5);   chk("s2_beat_frozen", beat_cnt, 96);

    // 3: wrong at both bar ends
    restart = 1'b1; step(1); restart = 1'b0;
    chk("s3_restart_clr", cleared, 0);
    start = 1'b1; wrong = 1'b1; step(1); start = 1'b0;
    step(193); chk("s3_lives1", lives, 1);
    step(194);
    chk("s3_lives0", lives, 0);
    chk("s3_go", game_over, 1);
    chk("s3_not_cleared", cleared, 0);
    chk("s3_soe", stop_or_end, 1);
    wrong = 1'b0;

    // 4: pause at beat 40
    restart = 1'b1; step(1); restart = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    step(80); chk("s4_beat40", beat_cnt, 40);
    pause = 1'b1; step(1); pause = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("s4_frozen", beat_cnt, 40);
      chk("s4_soe", stop_or_end, 1);
    end
    pause = 1'b1; step(1); pause = 1'b0;
    chk("s4_resume_soe", stop_or_end, 0);
    step(1); chk("s4_resume_beat", beat_cnt, 41);

    // 5: restart at beat 70 with simultaneous start
    step(58); chk("s5_beat70", beat_cnt, 70);
    restart = 1'b1; start = 1'b1; step(1); restart = 1'b0; start = 1'b0;
    chk("s5_beat", beat_cnt, 0);
    chk("s5_bar", bar_idx, 0);
    chk("s5_lives", lives, 2);
    chk("s5_soe", stop_or_end, 1);
    chk("s5_flags", {bar_end, cleared, game_over}, 0);
    step(2); chk("s5_start_ignored", stop_or_end, 1);

    // 6: asynchronous reset mid-bar, then wrong toggling off bar_end
    start = 1'b1; step(1); start = 1'b0;
    step(21);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_async_beat", beat_cnt, 0);
    chk("s6_async_soe", stop_or_end, 1);
    chk("s6_async_lives", lives, 2);
    step(2);
    rst_n = 1'b1;
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 0; i < 150; i++) begin
      wrong = i[0];
      step(1);
    end
    chk("s6_lives_kept", lives, 2);
    wrong = 1'b0;

    // randomized phase, checked cycle by cycle against the model
    for (int i = 0; i < 6000; i++) begin
      restart = ($urandom_range(0, 699) == 0);
      start   = ($urandom_range(0, 19) == 0);
      pause   = ($urandom_range(0, 79) == 0);
      wrong   = $urandom_range(0, 1) == 1;
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
